// File: rtl/axi_pkg.sv
// Shared AXI slave memory types: burst kinds, response codes, FSM states, ID width.
package axi_pkg;

   localparam int ID_W = 9;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED / INCR / WRAP bursts, plus WRAP length legality.
module axi_addr_gen
   import axi_pkg::*;
#(
   parameter int A_WIDTH = 16
) (
   input  logic [A_WIDTH-1:0] addr,
   input  logic [2:0]         size,
   input  logic [3:0]         len,
   input  logic [1:0]         burst,
   output logic [A_WIDTH-1:0] next_addr,
   output logic               wrap_legal
);

   logic [A_WIDTH-1:0] incr;
   logic [A_WIDTH-1:0] wrap_mask;
   logic [A_WIDTH-1:0] step_addr;

   // Illegal WRAP lengths and the reserved burst code step like INCR.
   always_comb begin
      incr       = A_WIDTH'(1) << size;
      wrap_mask  = ((A_WIDTH'(len) + A_WIDTH'(1)) << size) - A_WIDTH'(1);
      step_addr  = addr + incr;
      wrap_legal = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      next_addr  = step_addr;
      if (burst == BURST_FIXED)
         next_addr = addr;
      else if ((burst == BURST_WRAP) && wrap_legal)
         next_addr = (addr & ~wrap_mask) | (step_addr & wrap_mask);
   end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory model: one write and one read burst in flight, independent paths.
// Memory contents are deliberately not reset so an aborted burst keeps its written beats.
module axi_slave_mem
   import axi_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int D_WIDTH   = 16,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ID_W-1:0]      AWID,
   input  logic [A_WIDTH-1:0]   AWADDR,
   input  logic [3:0]           AWLEN,
   input  logic [2:0]           AWSIZE,
   input  logic [1:0]           AWBURST,
   input  logic                 AWVALID,
   output logic                 AWREADY,
   input  logic [ID_W-1:0]      WID,
   input  logic [D_WIDTH-1:0]   WDATA,
   input  logic [D_WIDTH/8-1:0] WSTRB,
   input  logic                 WLAST,
   input  logic                 WVALID,
   output logic                 WREADY,
   output logic [ID_W-1:0]      BID,
   output logic [1:0]           BRESP,
   output logic                 BVALID,
   input  logic                 BREADY,
   input  logic [ID_W-1:0]      ARID,
   input  logic [A_WIDTH-1:0]   ARADDR,
   input  logic [3:0]           ARLEN,
   input  logic [2:0]           ARSIZE,
   input  logic [1:0]           ARBURST,
   input  logic                 ARVALID,
   output logic                 ARREADY,
   output logic [ID_W-1:0]      RID,
   output logic [D_WIDTH-1:0]   RDATA,
   output logic [1:0]           RRESP,
   output logic                 RLAST,
   output logic                 RVALID,
   input  logic                 RREADY
);

   localparam int NB        = D_WIDTH / 8;
   localparam int LG_NB     = $clog2(NB);
   localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int MEM_BYTES = MEM_DEPTH * NB;

   logic [D_WIDTH-1:0] mem [MEM_DEPTH];
   logic               live;

   wstate_e            wstate, wstate_nxt;
   logic [ID_W-1:0]    awid_q;
   logic [A_WIDTH-1:0] waddr, wg_addr, w_next_addr;
   logic [3:0]         wlen, wcnt, wg_len;
   logic [2:0]         wsize, wg_size;
   logic [1:0]         wburst, wg_burst, bresp_q;
   logic               werr, w_wrap_legal, wg_size_err, wg_ctrl_err;
   logic               aw_hs, w_hs, w_last_beat, w_oor, w_beat_err, mem_we;
   logic [IDX_W-1:0]   w_idx;

   rstate_e            rstate, rstate_nxt;
   logic [ID_W-1:0]    arid_q;
   logic [A_WIDTH-1:0] raddr, rg_addr, r_next_addr, rd_addr;
   logic [3:0]         rlen, rcnt, rg_len;
   logic [2:0]         rsize, rg_size;
   logic [1:0]         rburst, rg_burst, rresp_q;
   logic [D_WIDTH-1:0] rdata_q;
   logic               rlast_q, r_wrap_legal, rg_size_err, rg_ctrl_err;
   logic               ar_hs, r_hs, rd_oor, rd_last, r_load;
   logic [IDX_W-1:0]   r_idx;

   // In idle the address generators look at the request channel so first-beat errors are known at the handshake.
   assign wg_addr  = (wstate == W_IDLE) ? AWADDR  : waddr;
   assign wg_len   = (wstate == W_IDLE) ? AWLEN   : wlen;
   assign wg_size  = (wstate == W_IDLE) ? AWSIZE  : wsize;
   assign wg_burst = (wstate == W_IDLE) ? AWBURST : wburst;
   assign rg_addr  = (rstate == R_IDLE) ? ARADDR  : raddr;
   assign rg_len   = (rstate == R_IDLE) ? ARLEN   : rlen;
   assign rg_size  = (rstate == R_IDLE) ? ARSIZE  : rsize;
   assign rg_burst = (rstate == R_IDLE) ? ARBURST : rburst;

   axi_addr_gen #(.A_WIDTH(A_WIDTH)) u_wgen (
      .addr(wg_addr), .size(wg_size), .len(wg_len), .burst(wg_burst),
      .next_addr(w_next_addr), .wrap_legal(w_wrap_legal));

   axi_addr_gen #(.A_WIDTH(A_WIDTH)) u_rgen (
      .addr(rg_addr), .size(rg_size), .len(rg_len), .burst(rg_burst),
      .next_addr(r_next_addr), .wrap_legal(r_wrap_legal));

   assign wg_size_err = int'(wg_size) > LG_NB;
   assign wg_ctrl_err = wg_size_err | (wg_burst == BURST_RSVD) | ((wg_burst == BURST_WRAP) & ~w_wrap_legal);
   assign rg_size_err = int'(rg_size) > LG_NB;
   assign rg_ctrl_err = rg_size_err | (rg_burst == BURST_RSVD) | ((rg_burst == BURST_WRAP) & ~r_wrap_legal);

   assign aw_hs       = AWVALID & AWREADY;
   assign w_hs        = WVALID & WREADY;
   assign w_last_beat = (wcnt == wlen);
   assign w_oor       = 32'(waddr) >= 32'(MEM_BYTES);
   assign w_beat_err  = w_oor | wg_ctrl_err | (WID != awid_q) | (WLAST != w_last_beat);
   assign mem_we      = w_hs & ~wg_size_err & ~w_oor;
   assign w_idx       = IDX_W'(waddr >> LG_NB);
   assign BID         = awid_q;
   assign BRESP       = bresp_q;

   assign ar_hs   = ARVALID & ARREADY;
   assign r_hs    = RVALID & RREADY;
   assign rd_addr = (rstate == R_IDLE) ? ARADDR : r_next_addr;
   assign rd_oor  = 32'(rd_addr) >= 32'(MEM_BYTES);
   assign rd_last = (rstate == R_IDLE) ? (ARLEN == 4'd0) : ((rcnt + 4'd1) == rlen);
   assign r_load  = ar_hs | (r_hs & ~RLAST);
   assign r_idx   = IDX_W'(rd_addr >> LG_NB);
   assign RID     = arid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;

   // Holds the ready outputs low until the first edge after reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   // State registers for both FSMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate <= W_IDLE;
         rstate <= R_IDLE;
      end else begin
         wstate <= wstate_nxt;
         rstate <= rstate_nxt;
      end
   end

   // Write FSM next state and handshake outputs.
   always_comb begin
      wstate_nxt = wstate;
      AWREADY    = 1'b0;
      WREADY     = 1'b0;
      BVALID     = 1'b0;
      case (wstate)
         W_IDLE: begin
            AWREADY = live;
            if (AWVALID && live) wstate_nxt = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && w_last_beat) wstate_nxt = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) wstate_nxt = W_IDLE;
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   // Read FSM next state and handshake outputs.
   always_comb begin
      rstate_nxt = rstate;
      ARREADY    = 1'b0;
      RVALID     = 1'b0;
      case (rstate)
         R_IDLE: begin
            ARREADY = live;
            if (ARVALID && live) rstate_nxt = R_DATA;
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY && RLAST) rstate_nxt = R_IDLE;
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // Write burst capture, beat stepping and error accumulation into BRESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awid_q  <= '0;
         waddr   <= '0;
         wlen    <= '0;
         wsize   <= '0;
         wburst  <= '0;
         wcnt    <= '0;
         werr    <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else if (aw_hs) begin
         awid_q <= AWID;
         waddr  <= AWADDR;
         wlen   <= AWLEN;
         wsize  <= AWSIZE;
         wburst <= AWBURST;
         wcnt   <= '0;
         werr   <= 1'b0;
      end else if (w_hs) begin
         waddr <= w_next_addr;
         wcnt  <= wcnt + 4'd1;
         werr  <= werr | w_beat_err;
         if (w_last_beat) bresp_q <= (werr | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // Byte-strobed storage write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++)
            if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
   end

   // Read burst capture and registered beat data; a same-cycle write is seen only by later beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arid_q  <= '0;
         raddr   <= '0;
         rlen    <= '0;
         rsize   <= '0;
         rburst  <= '0;
         rcnt    <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else begin
         if (ar_hs) begin
            arid_q <= ARID;
            raddr  <= ARADDR;
            rlen   <= ARLEN;
            rsize  <= ARSIZE;
            rburst <= ARBURST;
            rcnt   <= '0;
         end else if (r_hs) begin
            raddr <= r_next_addr;
            rcnt  <= rcnt + 4'd1;
         end
         if (r_load) begin
            rdata_q <= (rg_size_err | rd_oor) ? '0 : mem[r_idx];
            rresp_q <= (rg_ctrl_err | rd_oor) ? RESP_SLVERR : RESP_OKAY;
            rlast_q <= rd_last;
         end
      end
   end

endmodule
